// File: rtl/ltl_monitor_sequencer.sv
// ltl_monitor_sequencer: buffers trace symbols, drives the reset/run pair of
// one LTL automaton cluster and returns each non-zero report vector together
// with the index of the symbol that produced it over a valid/ready port.
module ltl_monitor_sequencer #(
    parameter int SYM_W    = 8,
    parameter int N_RPT    = 4,
    parameter int DEPTH    = 8,
    parameter int IDX_W    = 16,
    parameter int INIT_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_sym,
    input  logic             in_last,
    output logic             in_ready,
    output logic             auto_reset,
    output logic             auto_run,
    output logic [SYM_W-1:0] auto_sym,
    input  logic [N_RPT-1:0] auto_report,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [N_RPT-1:0] rpt_vec,
    output logic [IDX_W-1:0] rpt_idx,
    output logic             busy,
    output logic             done
);
    localparam int                PTR_W     = $clog2(DEPTH);
    localparam int                ICNT_W    = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(DEPTH);
    localparam logic [ICNT_W-1:0] INIT_LAST = ICNT_W'(INIT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_FLUSH} state_t;

    state_t              state_q, state_d;
    logic [ICNT_W-1:0]   init_cnt_q;
    logic [SYM_W:0]      fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      fcnt_q;
    logic                last_seen_q, pend_q;
    logic [IDX_W-1:0]    next_idx_q, cur_idx_q;
    logic [SYM_W-1:0]    sym_hold_q;
    logic [N_RPT-1:0]    rb_vec_q [2];
    logic [IDX_W-1:0]    rb_idx_q [2];
    logic                rb_wr_q, rb_rd_q;
    logic [1:0]          rb_cnt_q;

    logic                fifo_full, fifo_empty, push, issue, init_clr, capture, rpt_pop;
    logic [SYM_W:0]      fifo_head;

    assign fifo_head  = fifo_mem_q[rd_ptr_q];
    assign fifo_full  = (fcnt_q == FULL_CNT);
    assign fifo_empty = (fcnt_q == '0);
    assign push       = in_valid & in_ready;
    assign init_clr   = (state_q == S_IDLE) & start;
    assign capture    = pend_q & (auto_report != '0);
    assign rpt_pop    = rpt_valid & rpt_ready;

    // Next-state and handshake decode; an issue needs a buffered symbol and
    // room for its report among the held and in-flight reports.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        issue    = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                in_ready = !fifo_full;
                if (init_cnt_q == INIT_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                in_ready = !fifo_full && !last_seen_q;
                if (!fifo_empty && ((rb_cnt_q + {1'b0, pend_q}) < 2'd2)) begin
                    issue = 1'b1;
                    if (fifo_head[SYM_W]) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!pend_q && (rb_cnt_q == 2'd0)) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign auto_run   = issue;
    assign auto_reset = reset | (state_q == S_INIT);
    assign auto_sym   = issue ? fifo_head[SYM_W-1:0] : sym_hold_q;
    assign busy       = (state_q != S_IDLE);
    assign rpt_valid  = (rb_cnt_q != 2'd0);
    assign rpt_vec    = rpt_valid ? rb_vec_q[rb_rd_q] : '0;
    assign rpt_idx    = rpt_valid ? rb_idx_q[rb_rd_q] : '0;

    // State register and INIT dwell counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= (state_q == S_INIT) ? init_cnt_q + 1'b1 : '0;
        end
    end

    // Symbol FIFO pointers and occupancy; emptied at every trace start.
    always_ff @(posedge clk) begin
        if (reset || init_clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (issue) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !issue)      fcnt_q <= fcnt_q + 1'b1;
            else if (!push && issue) fcnt_q <= fcnt_q - 1'b1;
        end
    end

    // Symbol FIFO storage, the last flag travels above the symbol bits.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {in_last, in_sym};
    end

    // Per-trace bookkeeping: end-of-trace seen, capture pending, symbol index.
    always_ff @(posedge clk) begin
        if (reset || init_clr) begin
            last_seen_q <= 1'b0;
            pend_q      <= 1'b0;
            next_idx_q  <= '0;
            cur_idx_q   <= '0;
        end else begin
            if (push && in_last) last_seen_q <= 1'b1;
            pend_q <= issue;
            if (issue) begin
                cur_idx_q <= next_idx_q;
                if (next_idx_q != '1) next_idx_q <= next_idx_q + 1'b1;
            end
        end
    end

    // Hold the last issued symbol on the automaton input between issues.
    always_ff @(posedge clk) begin
        if (reset)      sym_hold_q <= '0;
        else if (issue) sym_hold_q <= fifo_head[SYM_W-1:0];
    end

    // Report buffer control; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            rb_wr_q  <= 1'b0;
            rb_rd_q  <= 1'b0;
            rb_cnt_q <= 2'd0;
        end else begin
            if (capture) rb_wr_q <= ~rb_wr_q;
            if (rpt_pop) rb_rd_q <= ~rb_rd_q;
            if (capture && !rpt_pop)      rb_cnt_q <= rb_cnt_q + 1'b1;
            else if (!capture && rpt_pop) rb_cnt_q <= rb_cnt_q - 1'b1;
        end
    end

    // Report buffer storage: captured vector tagged with its symbol index.
    always_ff @(posedge clk) begin
        if (capture) begin
            rb_vec_q[rb_wr_q] <= auto_report;
            rb_idx_q[rb_wr_q] <= cur_idx_q;
        end
    end

endmodule

// File: tb/tb_ltl_monitor_sequencer.sv
// Testbench for ltl_monitor_sequencer: directed vector table plus
// hand-written multi-cycle sequences against an automaton stub.
module tb_ltl_monitor_sequencer;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, rpt_ready = 1'b0;
    logic [7:0] in_sym = 8'h00;
    logic [3:0] auto_report;

    logic        in_ready, auto_reset, auto_run, rpt_valid, busy, done;
    logic [7:0]  auto_sym;
    logic [3:0]  rpt_vec;
    logic [15:0] rpt_idx;

    logic        in_ready2, auto_reset2, auto_run2, rpt_valid2, busy2, done2;
    logic [7:0]  auto_sym2;
    logic [3:0]  rpt_vec2;
    logic [1:0]  rpt_idx2;

    ltl_monitor_sequencer #(.SYM_W(8), .N_RPT(4), .DEPTH(8), .IDX_W(16), .INIT_CYC(2)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_sym(in_sym),
        .in_last(in_last), .in_ready(in_ready), .auto_reset(auto_reset), .auto_run(auto_run),
        .auto_sym(auto_sym), .auto_report(auto_report), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .rpt_vec(rpt_vec), .rpt_idx(rpt_idx), .busy(busy), .done(done)
    );

    // Narrow-index copy fed the same stimulus; it must run in lockstep.
    ltl_monitor_sequencer #(.SYM_W(8), .N_RPT(4), .DEPTH(8), .IDX_W(2), .INIT_CYC(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_sym(in_sym),
        .in_last(in_last), .in_ready(in_ready2), .auto_reset(auto_reset2), .auto_run(auto_run2),
        .auto_sym(auto_sym2), .auto_report(auto_report), .rpt_valid(rpt_valid2),
        .rpt_ready(rpt_ready), .rpt_vec(rpt_vec2), .rpt_idx(rpt_idx2), .busy(busy2), .done(done2)
    );

    // Automaton stub: report appears the cycle after a run.
    int         stub_mode = 0;
    logic [3:0] stub_q = 4'h0;
    always @(posedge clk) begin
        if (!auto_run)           stub_q <= 4'h0;
        else if (stub_mode == 1) stub_q <= 4'b0001;
        else                     stub_q <= (auto_sym == 8'h85) ? 4'b0100 : 4'b0000;
    end
    assign auto_report = stub_q;

    // Monitor: counts done/run pulses, records accepted reports.
    int          done_cnt = 0, run_cnt = 0, lock_err = 0;
    logic [3:0]  q_vec[$];
    logic [15:0] q_idx[$];
    logic [1:0]  q_idx2[$];
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (auto_run) run_cnt <= run_cnt + 1;
        if (rpt_valid && rpt_ready) begin
            q_vec.push_back(rpt_vec);
            q_idx.push_back(rpt_idx);
        end
        if (rpt_valid2 && rpt_ready) q_idx2.push_back(rpt_idx2);
        if ({in_ready2, auto_reset2, auto_run2, auto_sym2, rpt_valid2, rpt_vec2, busy2, done2} !==
            {in_ready, auto_reset, auto_run, auto_sym, rpt_valid, rpt_vec, busy, done})
            lock_err <= lock_err + 1;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic push_sym(input logic [7:0] s, input logic l);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1; in_sym = s; in_last = l;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                cyc();
                break;
            end
            cyc();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input int base, input int target, input int bound);
        for (int k = 0; k < bound; k++) begin
            if (done_cnt - base >= target) break;
            cyc();
        end
        chk("done_count", 32'(done_cnt - base), 32'(target));
    endtask

    typedef struct packed {
        logic [2:0]  ctl;    // {reset, start, in_valid}
        logic [7:0]  sym;
        logic        last;
        logic [5:0]  ef;     // {auto_reset, auto_run, in_ready, rpt_valid, busy, done}
        logic [7:0]  e_sym;
        logic [3:0]  e_vec;
        logic [15:0] e_idx;
    } vec_t;

    vec_t vt [12];
    int   exp6 [6];

    initial begin
        int base, qb, qb2, acc;
        vt[0]  = '{3'b100, 8'h00, 1'b0, 6'b100000, 8'h00, 4'h0, 16'd0};
        vt[1]  = '{3'b000, 8'h00, 1'b0, 6'b000000, 8'h00, 4'h0, 16'd0};
        vt[2]  = '{3'b010, 8'h00, 1'b0, 6'b000000, 8'h00, 4'h0, 16'd0};
        vt[3]  = '{3'b001, 8'h05, 1'b0, 6'b101010, 8'h00, 4'h0, 16'd0};
        vt[4]  = '{3'b001, 8'h25, 1'b0, 6'b101010, 8'h00, 4'h0, 16'd0};
        vt[5]  = '{3'b001, 8'h85, 1'b1, 6'b011010, 8'h05, 4'h0, 16'd0};
        vt[6]  = '{3'b000, 8'h00, 1'b0, 6'b010010, 8'h25, 4'h0, 16'd0};
        vt[7]  = '{3'b000, 8'h00, 1'b0, 6'b010010, 8'h85, 4'h0, 16'd0};
        vt[8]  = '{3'b000, 8'h00, 1'b0, 6'b000010, 8'h85, 4'h0, 16'd0};
        vt[9]  = '{3'b000, 8'h00, 1'b0, 6'b000110, 8'h85, 4'h4, 16'd2};
        vt[10] = '{3'b000, 8'h00, 1'b0, 6'b000011, 8'h85, 4'h0, 16'd0};
        vt[11] = '{3'b000, 8'h00, 1'b0, 6'b000000, 8'h85, 4'h0, 16'd0};
        exp6 = '{0, 1, 2, 3, 3, 3};

        // Reset state and basic three-symbol trace.
        stub_mode = 0;
        rpt_ready = 1'b1;
        cyc();
        for (int i = 0; i < 12; i++) begin
            {reset, start, in_valid} = vt[i].ctl;
            in_sym  = vt[i].sym;
            in_last = vt[i].last;
            #1;
            chk($sformatf("row%0d auto_reset", i), 32'(auto_reset), 32'(vt[i].ef[5]));
            chk($sformatf("row%0d auto_run", i),   32'(auto_run),   32'(vt[i].ef[4]));
            chk($sformatf("row%0d in_ready", i),   32'(in_ready),   32'(vt[i].ef[3]));
            chk($sformatf("row%0d rpt_valid", i),  32'(rpt_valid),  32'(vt[i].ef[2]));
            chk($sformatf("row%0d busy", i),       32'(busy),       32'(vt[i].ef[1]));
            chk($sformatf("row%0d done", i),       32'(done),       32'(vt[i].ef[0]));
            chk($sformatf("row%0d auto_sym", i),   32'(auto_sym),   32'(vt[i].e_sym));
            chk($sformatf("row%0d rpt_vec", i),    32'(rpt_vec),    32'(vt[i].e_vec));
            chk($sformatf("row%0d rpt_idx", i),    32'(rpt_idx),    32'(vt[i].e_idx));
            cyc();
        end
        {reset, start, in_valid, in_last} = 4'b0000;

        // Backpressure: six symbols, consumer stalled.
        stub_mode = 1;
        do_reset();
        rpt_ready = 1'b0;
        base = done_cnt; qb = q_idx.size();
        start = 1'b1; cyc(); start = 1'b0;
        acc = run_cnt;
        for (int i = 0; i < 6; i++) push_sym(8'h10 + 8'(i), i == 5);
        repeat (6) cyc();
        chk("stall_issues", 32'(run_cnt - acc), 32'd2);
        chk("stall_rpt_valid", 32'(rpt_valid), 32'd1);
        chk("stall_rpt_vec", 32'(rpt_vec), 32'd1);
        chk("stall_rpt_idx", 32'(rpt_idx), 32'd0);
        rpt_ready = 1'b1;
        wait_done(base, 1, 60);
        chk("bp_nrpt", 32'(q_idx.size() - qb), 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("bp_idx%0d", k), 32'(q_idx[qb + k]), 32'(k));
            chk($sformatf("bp_vec%0d", k), 32'(q_vec[qb + k]), 32'd1);
        end

        // FIFO full while stalled, ninth symbol after first report pop.
        do_reset();
        rpt_ready = 1'b0;
        base = done_cnt; qb = q_idx.size();
        start = 1'b1; cyc(); start = 1'b0;
        push_sym(8'h31, 1'b0);
        push_sym(8'h32, 1'b0);
        repeat (8) cyc();
        acc = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_sym = 8'h40 + 8'(acc); in_last = (acc == 8);
            #1;
            if (!in_ready) break;
            acc++;
            cyc();
        end
        chk("full_accepts", 32'(acc), 32'd8);
        cyc(); #1;
        chk("full_hold_ready", 32'(in_ready), 32'd0);
        cyc();
        rpt_ready = 1'b1; #1;
        chk("pop_rpt_valid", 32'(rpt_valid), 32'd1);
        chk("pop_cycle_ready", 32'(in_ready), 32'd0);
        cyc();
        rpt_ready = 1'b0; #1;
        chk("resume_ready", 32'(in_ready), 32'd0);
        chk("resume_run", 32'(auto_run), 32'd1);
        cyc(); #1;
        chk("ninth_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0; in_last = 1'b0;
        rpt_ready = 1'b1;
        wait_done(base, 1, 80);
        chk("full_nrpt", 32'(q_idx.size() - qb), 32'd11);
        for (int k = 0; k < 11; k++) chk($sformatf("full_idx%0d", k), 32'(q_idx[qb + k]), 32'(k));

        // Reset in the cycle after the second issue.
        do_reset();
        rpt_ready = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        in_valid = 1'b1; in_sym = 8'h11; #1;
        chk("r_init_ar", 32'(auto_reset), 32'd1);
        cyc();
        in_sym = 8'h12; cyc();
        in_sym = 8'h13; #1;
        chk("r_issue1_run", 32'(auto_run), 32'd1);
        chk("r_issue1_sym", 32'(auto_sym), 32'h11);
        cyc();
        in_sym = 8'h14; in_last = 1'b1; #1;
        chk("r_issue2_run", 32'(auto_run), 32'd1);
        chk("r_issue2_sym", 32'(auto_sym), 32'h12);
        cyc();
        in_valid = 1'b0; in_last = 1'b0; reset = 1'b1; #1;
        chk("r_hold_ar", 32'(auto_reset), 32'd1);
        cyc();
        reset = 1'b0; #1;
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_rpt_valid", 32'(rpt_valid), 32'd0);
        chk("r_in_ready", 32'(in_ready), 32'd0);
        chk("r_auto_reset", 32'(auto_reset), 32'd0);
        chk("r_auto_sym", 32'(auto_sym), 32'd0);
        cyc();
        base = done_cnt; qb = q_idx.size();
        start = 1'b1; cyc(); start = 1'b0;
        in_valid = 1'b1; in_sym = 8'h21; #1;
        chk("r2_init1_ar", 32'(auto_reset), 32'd1);
        chk("r2_init1_rdy", 32'(in_ready), 32'd1);
        cyc();
        in_sym = 8'h22; in_last = 1'b1; #1;
        chk("r2_init2_ar", 32'(auto_reset), 32'd1);
        cyc();
        in_valid = 1'b0; in_last = 1'b0; #1;
        chk("r2_run_ar", 32'(auto_reset), 32'd0);
        chk("r2_run", 32'(auto_run), 32'd1);
        chk("r2_sym", 32'(auto_sym), 32'h21);
        wait_done(base, 1, 40);
        chk("r2_nrpt", 32'(q_idx.size() - qb), 32'd2);
        chk("r2_idx0", 32'(q_idx[qb]), 32'd0);
        chk("r2_idx1", 32'(q_idx[qb + 1]), 32'd1);

        // Start during RUN and a symbol offered after the last one.
        do_reset();
        base = done_cnt; qb = q_idx.size();
        start = 1'b1; cyc(); start = 1'b0;
        in_valid = 1'b1; in_sym = 8'h51; cyc();
        in_sym = 8'h52; in_last = 1'b1; cyc();
        start = 1'b1; in_sym = 8'h53; in_last = 1'b0; #1;
        chk("late_busy", 32'(busy), 32'd1);
        chk("late_ready", 32'(in_ready), 32'd0);
        cyc();
        start = 1'b0; #1;
        chk("late_ready2", 32'(in_ready), 32'd0);
        wait_done(base, 1, 40);
        repeat (4) cyc();
        in_valid = 1'b0;
        chk("late_single_done", 32'(done_cnt - base), 32'd1);
        chk("late_idle", 32'(busy), 32'd0);
        chk("late_nrpt", 32'(q_idx.size() - qb), 32'd2);

        // Index saturation on the 2-bit copy.
        do_reset();
        base = done_cnt; qb2 = q_idx2.size();
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 6; i++) push_sym(8'h60 + 8'(i), i == 5);
        wait_done(base, 1, 60);
        chk("sat_nrpt", 32'(q_idx2.size() - qb2), 32'd6);
        for (int k = 0; k < 6; k++) chk($sformatf("sat_idx%0d", k), 32'(q_idx2[qb2 + k]), 32'(exp6[k]));

        cyc();
        chk("lockstep", 32'(lock_err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
